// File: rtl/wasm_pkg.sv
// wasm_pkg: shared types for the call/return sequencer (trap codes, frames, function descriptors, FSM states)
package wasm_pkg;
  localparam int OPERAND_STACK_DEPTH = 1024;
  typedef enum logic [2:0] {
    TRAP_NONE,
    TRAP_CALL_STACK_EXHAUSTED,
    TRAP_STACK_UNDERFLOW,
    TRAP_STACK_OVERFLOW
  } trap_t;
  typedef struct packed {
    logic [31:0] return_pc;
    logic [15:0] locals_base;
    logic [15:0] func_idx;
  } frame_entry_t;
  typedef struct packed {
    logic [31:0] entry_pc;
    logic [15:0] num_params;
    logic [15:0] num_locals;
    logic [15:0] num_results;
  } func_info_t;
  typedef enum logic [2:0] {
    CC_IDLE, CC_FETCH, CC_CHECK, CC_ZERO, CC_PUSH, CC_RET, CC_DONE, CC_TRAP
  } call_ctrl_state_t;
endpackage

// File: rtl/wasm_call_ctrl_locals_init.sv
// wasm_locals_init: issues one zero write per cycle over base..base+count-1 and flags the final write
module wasm_locals_init (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [15:0] i_base,
  input  logic [15:0] i_count,
  output logic        o_wr_en,
  output logic [15:0] o_wr_addr,
  output logic        o_last
);
  logic        r_busy;
  logic [15:0] r_base, r_count, r_k;
  // Walk k from 0 up to count-1; start is only raised for a non-zero count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_base  <= '0;
      r_count <= '0;
      r_k     <= '0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_base  <= i_base;
      r_count <= i_count;
      r_k     <= '0;
    end else if (r_busy) begin
      r_k    <= r_k + 16'd1;
      r_busy <= !o_last;
    end
  end
  assign o_wr_en   = r_busy;
  assign o_wr_addr = r_base + r_k;
  assign o_last    = r_busy && (r_k == r_count - 16'd1);
endmodule

// File: rtl/wasm_call_ctrl.sv
// wasm_call_ctrl: call/return sequencer; optional tail calls under WASM_TAIL_CALL_EN
module wasm_call_ctrl import wasm_pkg::*; #(
  parameter int OPSTACK_DEPTH = OPERAND_STACK_DEPTH,
  parameter int FUNC_IDX_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  call_req,
  input  logic [FUNC_IDX_W-1:0] call_func_idx,
  input  logic [31:0]           call_return_pc,
  input  logic                  ret_req,
`ifdef WASM_TAIL_CALL_EN
  input  logic                  tail_req,
`endif
  input  logic [15:0]           operand_sp,
  output logic                  ready,
  output logic                  done,
  output logic [31:0]           done_pc,
  output logic [15:0]           done_locals_base,
  output logic [15:0]           done_operand_sp,
  output logic                  done_halt,
  output trap_t                 trap,
  output logic                  ft_rd_en,
  output logic [FUNC_IDX_W-1:0] ft_rd_addr,
  input  func_info_t            ft_rd_data,
  output logic                  loc_wr_en,
  output logic [15:0]           loc_wr_addr,
  output logic [31:0]           loc_wr_data,
  output logic                  cs_push_en,
  output logic                  cs_pop_en,
  output frame_entry_t          cs_push_data,
  input  frame_entry_t          cs_top,
  input  logic                  cs_empty,
  input  logic                  cs_full
);
  call_ctrl_state_t      r_state;
  logic [FUNC_IDX_W-1:0] r_idx;
  logic [31:0]           r_pc, r_done_pc;
  logic [15:0]           r_sp, r_done_base, r_done_sp;
  logic                  r_halt;
  trap_t                 r_trap;
  trap_t                 w_code;
  logic [16:0]           w_need;
  logic                  w_is_tail, w_tail_rep, w_req, w_start, w_last, w_unused;
`ifdef WASM_TAIL_CALL_EN
  logic r_tail;
  // Remember whether the accepted call was a tail call
  always_ff @(posedge clk)
    r_tail <= rst ? 1'b0 : (r_state == CC_IDLE && !ret_req && (call_req || tail_req)) ? tail_req : r_tail;
  assign w_is_tail = r_tail;
  assign w_req     = call_req || tail_req;
`else
  assign w_is_tail = 1'b0;
  assign w_req     = call_req;
`endif
  assign w_tail_rep = w_is_tail && !cs_empty;
  assign w_need     = {1'b0, r_sp} + {1'b0, ft_rd_data.num_locals};
  assign w_code     = (cs_full && !w_is_tail) ? TRAP_CALL_STACK_EXHAUSTED :
                      (r_sp < ft_rd_data.num_params) ? TRAP_STACK_UNDERFLOW :
                      (w_need > 17'(OPSTACK_DEPTH)) ? TRAP_STACK_OVERFLOW : TRAP_NONE;
  assign w_start    = r_state == CC_CHECK && w_code == TRAP_NONE && ft_rd_data.num_locals != 16'd0;
  assign w_unused   = &{1'b0, ft_rd_data.num_results, cs_top.func_idx};
  wasm_locals_init u_init (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_start),
    .i_base    (r_sp),
    .i_count   (ft_rd_data.num_locals),
    .o_wr_en   (loc_wr_en),
    .o_wr_addr (loc_wr_addr),
    .o_last    (w_last)
  );
  // Sequencer: accept, fetch descriptor, check limits, zero locals, push or pop, report
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= CC_IDLE;
      r_idx       <= '0;
      r_pc        <= '0;
      r_sp        <= '0;
      r_done_pc   <= '0;
      r_done_base <= '0;
      r_done_sp   <= '0;
      r_halt      <= 1'b0;
      r_trap      <= TRAP_NONE;
    end else begin
      case (r_state)
        CC_IDLE: if (ret_req || w_req) begin
          r_state <= ret_req ? CC_RET : CC_FETCH;
          r_idx   <= call_func_idx;
          r_pc    <= call_return_pc;
          r_sp    <= operand_sp;
        end
        CC_FETCH: r_state <= CC_CHECK;
        CC_CHECK: begin
          r_trap      <= w_code;
          r_done_pc   <= ft_rd_data.entry_pc;
          r_done_base <= r_sp - ft_rd_data.num_params;
          r_done_sp   <= w_need[15:0];
          r_halt      <= 1'b0;
          r_state     <= (w_code != TRAP_NONE) ? CC_TRAP :
                         (ft_rd_data.num_locals != 16'd0) ? CC_ZERO : CC_PUSH;
        end
        CC_ZERO: if (w_last) r_state <= CC_PUSH;
        CC_PUSH: r_state <= CC_DONE;
        CC_RET: begin
          r_halt      <= cs_empty;
          r_done_pc   <= cs_empty ? 32'd0 : cs_top.return_pc;
          r_done_base <= cs_empty ? 16'd0 : cs_top.locals_base;
          r_done_sp   <= cs_empty ? 16'd0 : cs_top.locals_base;
          r_state     <= CC_DONE;
        end
        CC_DONE: r_state <= CC_IDLE;
        default: r_state <= CC_TRAP;
      endcase
    end
  end
  assign ready            = r_state == CC_IDLE;
  assign done             = r_state == CC_DONE;
  assign done_pc          = r_done_pc;
  assign done_locals_base = r_done_base;
  assign done_operand_sp  = r_done_sp;
  assign done_halt        = r_halt;
  assign trap             = r_trap;
  assign ft_rd_en         = r_state == CC_FETCH;
  assign ft_rd_addr       = r_idx;
  assign loc_wr_data      = 32'd0;
  assign cs_push_en       = r_state == CC_PUSH;
  assign cs_pop_en        = (r_state == CC_RET && !cs_empty) || (r_state == CC_PUSH && w_tail_rep);
  assign cs_push_data     = '{return_pc:   w_tail_rep ? cs_top.return_pc : r_pc,
                              locals_base: r_done_base,
                              func_idx:    16'(r_idx)};
endmodule

// File: tb/tb_wasm_call_ctrl.sv
// tb_wasm_call_ctrl: table-driven directed checks of call/return sequencing, traps and reset abort
module tb_wasm_call_ctrl;
  import wasm_pkg::*;
  logic         clk = 0, rst = 1, call_req = 0, ret_req = 0;
  logic [15:0]  call_func_idx = 0, operand_sp = 0;
  logic [31:0]  call_return_pc = 0;
  logic         ready, done, done_halt, ft_rd_en, loc_wr_en, cs_push_en, cs_pop_en;
  logic [31:0]  done_pc, loc_wr_data;
  logic [15:0]  done_locals_base, done_operand_sp, ft_rd_addr, loc_wr_addr;
  trap_t        trap;
  func_info_t   ft_rd_data = '0;
  frame_entry_t cs_push_data, cs_top = '0;
  logic         cs_empty = 0, cs_full = 0;
  int           n_cmp = 0, n_fail = 0;

  typedef struct {
    logic ret, call; logic [15:0] idx; logic [31:0] pc; logic [15:0] sp;
    logic empty, full; frame_entry_t top;
    int e_done; logic [31:0] e_pc; logic [15:0] e_base, e_sp; logic e_halt;
    int e_nwr; int e_push; frame_entry_t e_pdata; int e_pop; trap_t e_trap; int e_tcyc;
  } vec_t;

  always #5 clk = ~clk;

  wasm_call_ctrl dut (
    .clk(clk), .rst(rst), .call_req(call_req), .call_func_idx(call_func_idx),
    .call_return_pc(call_return_pc), .ret_req(ret_req), .operand_sp(operand_sp),
    .ready(ready), .done(done), .done_pc(done_pc), .done_locals_base(done_locals_base),
    .done_operand_sp(done_operand_sp), .done_halt(done_halt), .trap(trap),
    .ft_rd_en(ft_rd_en), .ft_rd_addr(ft_rd_addr), .ft_rd_data(ft_rd_data),
    .loc_wr_en(loc_wr_en), .loc_wr_addr(loc_wr_addr), .loc_wr_data(loc_wr_data),
    .cs_push_en(cs_push_en), .cs_pop_en(cs_pop_en), .cs_push_data(cs_push_data),
    .cs_top(cs_top), .cs_empty(cs_empty), .cs_full(cs_full)
  );

  function automatic func_info_t ft_lookup(input logic [15:0] a);
    case (a)
      16'd3:   return {32'h100, 16'd2, 16'd3,  16'd0};
      16'd5:   return {32'h200, 16'd1, 16'd0,  16'd1};
      16'd7:   return {32'h300, 16'd2, 16'd0,  16'd0};
      16'd9:   return {32'h400, 16'd0, 16'd20, 16'd0};
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) if (ft_rd_en) ft_rd_data <= ft_lookup(ft_rd_addr);

  task automatic chk(input string nm, input int vi, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got 0x%0h, want 0x%0h", nm, vi, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1; call_req = 0; ret_req = 0;
    @(posedge clk); @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic run_vec(input int vi, input vec_t t);
    int done_c = -1, push_c = -1, pop_c = -1, tcyc = -1, nwr = 0, n_push = 0, n_pop = 0, n_done = 0, last;
    logic [31:0] dpc = 0; logic [15:0] dbase = 0, dsp = 0; logic dhalt = 0;
    frame_entry_t pd = '0;
    do_reset();
    cs_empty = t.empty; cs_full = t.full; cs_top = t.top;
    @(negedge clk);
    ret_req = t.ret; call_req = t.call; call_func_idx = t.idx; call_return_pc = t.pc; operand_sp = t.sp;
    @(posedge clk);
    last = (t.e_done > 3 ? t.e_done : 3) + 3;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      ret_req = 0; call_req = 0;
      if (loc_wr_en) begin
        chk("zero_addr", vi, 64'(loc_wr_addr), 64'(t.sp + 16'(nwr)));
        nwr++;
      end
      if (cs_push_en) begin n_push++; if (push_c < 0) begin push_c = c; pd = cs_push_data; end end
      if (cs_pop_en) begin n_pop++; if (pop_c < 0) pop_c = c; end
      if (done) begin
        n_done++;
        if (done_c < 0) begin
          done_c = c; dpc = done_pc; dbase = done_locals_base; dsp = done_operand_sp; dhalt = done_halt;
        end
      end
      if (trap != TRAP_NONE && tcyc < 0) tcyc = c;
    end
    chk("done_cycle", vi, 64'(done_c), 64'(t.e_done));
    chk("done_count", vi, 64'(n_done), 64'(t.e_done >= 0));
    chk("zero_writes", vi, 64'(nwr), 64'(t.e_nwr));
    chk("push_cycle", vi, 64'(push_c), 64'(t.e_push));
    chk("push_count", vi, 64'(n_push), 64'(t.e_push >= 0));
    chk("pop_cycle", vi, 64'(pop_c), 64'(t.e_pop));
    chk("pop_count", vi, 64'(n_pop), 64'(t.e_pop >= 0));
    chk("trap_cycle", vi, 64'(tcyc), 64'(t.e_tcyc));
    chk("trap_code", vi, 64'(trap), 64'(t.e_trap));
    chk("ready_end", vi, 64'(ready), 64'(t.e_trap == TRAP_NONE));
    if (t.e_done >= 0) begin
      chk("done_pc", vi, 64'(dpc), 64'(t.e_pc));
      chk("done_locals_base", vi, 64'(dbase), 64'(t.e_base));
      chk("done_operand_sp", vi, 64'(dsp), 64'(t.e_sp));
      chk("done_halt", vi, 64'(dhalt), 64'(t.e_halt));
    end
    if (t.e_push >= 0) chk("push_data", vi, 64'(pd), 64'(t.e_pdata));
  endtask

  initial begin
    vec_t v[11];
    int n_push;
    //        ret call idx  pc          sp    emp full top                          done pc          base   sp     h nwr push pdata                          pop trap                        tcyc
    v[0]  = '{0, 1, 3,  32'h1234, 10,   0, 0, 64'h0,                         7,  32'h100, 8,     13,    0, 3,  6,  {32'h1234, 16'd8, 16'd3},    -1, TRAP_NONE,                 -1};
    v[1]  = '{0, 1, 5,  32'h50,   4,    0, 0, 64'h0,                         4,  32'h200, 3,     4,     0, 0,  3,  {32'h50, 16'd3, 16'd5},      -1, TRAP_NONE,                 -1};
    v[2]  = '{1, 0, 0,  32'h0,    0,    0, 0, {32'h44, 16'd8, 16'd2},        2,  32'h44,  8,     8,     0, 0,  -1, 64'h0,                       1,  TRAP_NONE,                 -1};
    v[3]  = '{1, 0, 0,  32'h0,    0,    1, 0, 64'h0,                         2,  32'h0,   0,     0,     1, 0,  -1, 64'h0,                       -1, TRAP_NONE,                 -1};
    v[4]  = '{0, 1, 3,  32'h10,   10,   0, 1, 64'h0,                         -1, 32'h0,   0,     0,     0, 0,  -1, 64'h0,                       -1, TRAP_CALL_STACK_EXHAUSTED, 3};
    v[5]  = '{0, 1, 7,  32'h10,   1,    0, 0, 64'h0,                         -1, 32'h0,   0,     0,     0, 0,  -1, 64'h0,                       -1, TRAP_STACK_UNDERFLOW,      3};
    v[6]  = '{0, 1, 9,  32'h10,   1005, 0, 0, 64'h0,                         -1, 32'h0,   0,     0,     0, 0,  -1, 64'h0,                       -1, TRAP_STACK_OVERFLOW,       3};
    v[7]  = '{0, 1, 9,  32'h77,   1004, 0, 0, 64'h0,                         24, 32'h400, 1004,  1024,  0, 20, 23, {32'h77, 16'd1004, 16'd9},   -1, TRAP_NONE,                 -1};
    v[8]  = '{1, 1, 3,  32'h99,   10,   0, 0, {32'h88, 16'd5, 16'd1},        2,  32'h88,  5,     5,     0, 0,  -1, 64'h0,                       1,  TRAP_NONE,                 -1};
    v[9]  = '{0, 1, 7,  32'h60,   2,    0, 0, 64'h0,                         4,  32'h300, 0,     2,     0, 0,  3,  {32'h60, 16'd0, 16'd7},      -1, TRAP_NONE,                 -1};
    v[10] = '{0, 1, 7,  32'h10,   1,    0, 1, 64'h0,                         -1, 32'h0,   0,     0,     0, 0,  -1, 64'h0,                       -1, TRAP_CALL_STACK_EXHAUSTED, 3};

    do_reset();
    @(negedge clk);
    chk("rst_ready", -1, 64'(ready), 64'd1);
    chk("rst_done", -1, 64'(done), 64'd0);
    chk("rst_trap", -1, 64'(trap), 64'(TRAP_NONE));
    chk("rst_strobes", -1, 64'({ft_rd_en, loc_wr_en, cs_push_en, cs_pop_en, done_halt}), 64'd0);
    chk("rst_data", -1, 64'(done_pc) | 64'(done_operand_sp) | 64'(done_locals_base) | 64'(cs_push_data), 64'd0);

    for (int i = 0; i < 11; i++) run_vec(i, v[i]);

    // reset in the middle of local zeroing abandons the call without a push
    do_reset();
    cs_empty = 0; cs_full = 0;
    @(negedge clk);
    call_req = 1; call_func_idx = 16'd9; call_return_pc = 32'hAB; operand_sp = 16'd100;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin @(negedge clk); call_req = 0; end
    chk("mid_zero_active", 100, 64'(loc_wr_en), 64'd1);
    chk("mid_zero_addr", 100, 64'(loc_wr_addr), 64'd102);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_ready", 100, 64'(ready), 64'd1);
    chk("mid_rst_wr", 100, 64'(loc_wr_en), 64'd0);
    rst = 0;
    n_push = 0;
    for (int c = 0; c < 30; c++) begin @(negedge clk); if (cs_push_en) n_push++; end
    chk("mid_rst_no_push", 100, 64'(n_push), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
